// File: rtl/wb_stage.sv
// wb_stage: dual-issue writeback that aligns slot-1 loads, merges divider results and forces a bubble after MAX_WAIT
// Ports: clk/resetn (sync, active-low); mem_inst{1,2}_* slot inputs from MEM; dmem_rdata load word;
// div_valid/div_wa/div_result/div_ready divider handshake; wb_stall holds MEM; inst{1,2}_we/wa/w2regdata register-file write ports.
module wb_stage #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_inst1_valid,
  input  logic        mem_inst1_we,
  input  logic [4:0]  mem_inst1_wa,
  input  logic [31:0] mem_inst1_result,
  input  logic [2:0]  mem_inst1_ld_op,
  input  logic [1:0]  mem_inst1_addr_lo,
  input  logic        mem_inst2_valid,
  input  logic        mem_inst2_we,
  input  logic [4:0]  mem_inst2_wa,
  input  logic [31:0] mem_inst2_result,
  input  logic [31:0] dmem_rdata,
  input  logic        div_valid,
  input  logic [4:0]  div_wa,
  input  logic [31:0] div_result,
  output logic        div_ready,
  output logic        wb_stall,
  output logic        inst1_we,
  output logic [4:0]  inst1_wa,
  output logic [31:0] inst1_w2regdata,
  output logic        inst2_we,
  output logic [4:0]  inst2_wa,
  output logic [31:0] inst2_w2regdata
);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, FORCE = 2'd2;
  localparam int CW = $clog2(MAX_WAIT + 2);
  logic [1:0]    state;
  logic [CW-1:0] cnt, cnt_inc;
  logic          s1_valid, s1_we, s2_valid, s2_we;
  logic [4:0]    s1_wa, s2_wa, pend_wa;
  logic [31:0]   s1_result, s2_result, pend_data, s1_data;
  logic [2:0]    s1_ld_op;
  logic [1:0]    s1_addr_lo;
  logic          pend_valid, s1_wr, s2_wr, s1_eff, grant1, grant2, grant, accept, keep;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  assign pend_valid = state != IDLE;
  assign wb_stall   = resetn & (state == FORCE);
  assign div_ready  = resetn & ~pend_valid;
  assign accept     = div_valid & div_ready;
  assign keep       = accept & (div_wa != 5'd0);
  // A collapsed slot 1 counts as idle, so the pending result may take port 1.
  always_comb begin
    s1_wr   = s1_valid & s1_we & (s1_wa != 5'd0);
    s2_wr   = s2_valid & s2_we & (s2_wa != 5'd0);
    s1_eff  = s1_wr & ~(s2_wr & (s1_wa == s2_wa));
    grant1  = pend_valid & ~s1_eff;
    grant2  = pend_valid & s1_eff & ~s2_wr;
    grant   = grant1 | grant2;
    cnt_inc = cnt + 1'b1;
    ld_byte = dmem_rdata[{s1_addr_lo, 3'b000} +: 8];
    ld_half = s1_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    s1_data = s1_ld_op == 3'd1 ? {{24{ld_byte[7]}}, ld_byte} :
              s1_ld_op == 3'd2 ? {24'd0, ld_byte} :
              s1_ld_op == 3'd3 ? {{16{ld_half[15]}}, ld_half} :
              s1_ld_op == 3'd4 ? {16'd0, ld_half} :
              s1_ld_op == 3'd5 ? dmem_rdata : s1_result;
  end
  assign inst1_we        = resetn & (s1_eff | grant1);
  assign inst1_wa        = !resetn ? 5'd0 : grant1 ? pend_wa : s1_eff ? s1_wa : 5'd0;
  assign inst1_w2regdata = !resetn ? 32'd0 : grant1 ? pend_data : s1_eff ? s1_data : 32'd0;
  assign inst2_we        = resetn & (s2_wr | grant2);
  assign inst2_wa        = !resetn ? 5'd0 : grant2 ? pend_wa : s2_wr ? s2_wa : 5'd0;
  assign inst2_w2regdata = !resetn ? 32'd0 : grant2 ? pend_data : s2_wr ? s2_result : 32'd0;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      s1_valid <= mem_inst1_valid & ~wb_stall;
      s2_valid <= mem_inst2_valid & ~wb_stall;
      if (keep) begin
        state <= HOLD;
        cnt   <= '0;
      end else if (pend_valid) begin
        if (grant) state <= IDLE;
        else if (state == FORCE) begin
          state <= HOLD;
          cnt   <= CW'(MAX_WAIT);
        end else begin
          cnt   <= cnt_inc;
          state <= cnt_inc >= CW'(MAX_WAIT) ? FORCE : HOLD;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    s1_we      <= mem_inst1_we;
    s1_wa      <= mem_inst1_wa;
    s1_result  <= mem_inst1_result;
    s1_ld_op   <= mem_inst1_ld_op;
    s1_addr_lo <= mem_inst1_addr_lo;
    s2_we      <= mem_inst2_we;
    s2_wa      <= mem_inst2_wa;
    s2_result  <= mem_inst2_result;
    if (keep) begin
      pend_wa   <= div_wa;
      pend_data <= div_result;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random checks of wb_stage against a behavioural writeback model
module tb_wb_stage;
  localparam int MAX_WAIT = 4;
  logic        clk = 1'b0, resetn;
  logic        mem_inst1_valid, mem_inst1_we, mem_inst2_valid, mem_inst2_we;
  logic [4:0]  mem_inst1_wa, mem_inst2_wa, div_wa;
  logic [31:0] mem_inst1_result, mem_inst2_result, dmem_rdata, div_result;
  logic [2:0]  mem_inst1_ld_op;
  logic [1:0]  mem_inst1_addr_lo;
  logic        div_valid, div_ready, wb_stall, inst1_we, inst2_we;
  logic [4:0]  inst1_wa, inst2_wa;
  logic [31:0] inst1_w2regdata, inst2_w2regdata;
  wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .mem_inst1_valid(mem_inst1_valid), .mem_inst1_we(mem_inst1_we), .mem_inst1_wa(mem_inst1_wa),
    .mem_inst1_result(mem_inst1_result), .mem_inst1_ld_op(mem_inst1_ld_op), .mem_inst1_addr_lo(mem_inst1_addr_lo),
    .mem_inst2_valid(mem_inst2_valid), .mem_inst2_we(mem_inst2_we), .mem_inst2_wa(mem_inst2_wa),
    .mem_inst2_result(mem_inst2_result), .dmem_rdata(dmem_rdata),
    .div_valid(div_valid), .div_wa(div_wa), .div_result(div_result), .div_ready(div_ready),
    .wb_stall(wb_stall), .inst1_we(inst1_we), .inst1_wa(inst1_wa), .inst1_w2regdata(inst1_w2regdata),
    .inst2_we(inst2_we), .inst2_wa(inst2_wa), .inst2_w2regdata(inst2_w2regdata)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] r;
    logic [2:0]  op;
    logic [1:0]  lo;
  } slot_t;
  slot_t       m1, m2;
  logic        p_have, pstall, g1, g2, e_stall, e_ready;
  logic [4:0]  p_wa;
  logic [31:0] p_d;
  int          age;
  int          n_assert = 0, n_fail = 0;
  int          n_st, n_r7;
  logic [2:0]  ops [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
  logic [31:0] lexp[4] = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4, 32'h12F45678};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] align(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] w, input logic [31:0] r);
    int unsigned b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (op)
      3'd1: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd2: return b;
      3'd3: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd4: return h;
      3'd5: return w;
      default: return r;
    endcase
  endfunction
  task automatic mem_set(input logic v1, input logic we1, input logic [4:0] wa1, input logic [31:0] r1,
                         input logic [2:0] op1, input logic [1:0] lo1,
                         input logic v2, input logic we2, input logic [4:0] wa2, input logic [31:0] r2);
    mem_inst1_valid = v1; mem_inst1_we = we1; mem_inst1_wa = wa1; mem_inst1_result = r1;
    mem_inst1_ld_op = op1; mem_inst1_addr_lo = lo1;
    mem_inst2_valid = v2; mem_inst2_we = we2; mem_inst2_wa = wa2; mem_inst2_result = r2;
  endtask
  task automatic mem_idle();
    mem_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic settle();
    logic w1, w2;
    @(negedge clk);
    w1 = m1.v && m1.we && m1.wa != 0;
    w2 = m2.v && m2.we && m2.wa != 0;
    if (w1 && w2 && m1.wa == m2.wa) w1 = 0;
    g1 = resetn && p_have && !w1;
    g2 = resetn && p_have && w1 && !w2;
    e_stall = resetn && p_have && age >= MAX_WAIT && !pstall;
    e_ready = resetn && !p_have;
    w1 = w1 && resetn;
    w2 = w2 && resetn;
    chk("inst1_we", inst1_we, w1 || g1);
    chk("inst1_wa", inst1_wa, g1 ? p_wa : w1 ? m1.wa : 5'd0);
    chk("inst1_data", inst1_w2regdata, g1 ? p_d : w1 ? align(m1.op, m1.lo, dmem_rdata, m1.r) : 32'd0);
    chk("inst2_we", inst2_we, w2 || g2);
    chk("inst2_wa", inst2_wa, g2 ? p_wa : w2 ? m2.wa : 5'd0);
    chk("inst2_data", inst2_w2regdata, g2 ? p_d : w2 ? m2.r : 32'd0);
    chk("wb_stall", wb_stall, e_stall);
    chk("div_ready", div_ready, e_ready);
  endtask
  task automatic clock_edge();
    @(posedge clk);
    if (!resetn) begin
      m1.v = 0; m2.v = 0; p_have = 0; age = 0; pstall = 0;
    end else begin
      if (g1 || g2) p_have = 0;
      else if (p_have) age++;
      if (div_valid && e_ready && div_wa != 0) begin
        p_have = 1; p_wa = div_wa; p_d = div_result; age = 0;
      end
      m1 = '{mem_inst1_valid && !e_stall, mem_inst1_we, mem_inst1_wa, mem_inst1_result, mem_inst1_ld_op, mem_inst1_addr_lo};
      m2 = '{mem_inst2_valid && !e_stall, mem_inst2_we, mem_inst2_wa, mem_inst2_result, 3'd0, 2'd0};
      pstall = e_stall;
    end
    #1;
  endtask
  task automatic both_busy();
    if (!pstall) mem_set(1, 1, 5'd8, $urandom, 0, 0, 1, 1, 5'd9, $urandom);
  endtask
  initial begin
    m1 = '0; m2 = '0; p_have = 0; pstall = 0; age = 0; p_wa = 0; p_d = 0;
    resetn = 0; div_valid = 1; div_wa = 5'd3; div_result = 32'h5; dmem_rdata = 0;
    mem_set(1, 1, 5'd1, 32'h1, 0, 0, 1, 1, 5'd2, 32'h2);
    repeat (2) begin
      settle();
      chk("rst_ready", div_ready, 0);
      chk("rst_we", {inst1_we, inst2_we, wb_stall}, 0);
      clock_edge();
    end
    resetn = 1; div_valid = 0;
    mem_set(1, 1, 5'd3, 32'h11, 0, 0, 1, 1, 5'd4, 32'h22);
    settle(); clock_edge();
    mem_idle();
    settle();
    chk("alu_wa", {inst1_we, inst1_wa, inst2_we, inst2_wa}, {1'b1, 5'd3, 1'b1, 5'd4});
    chk("alu_d1", inst1_w2regdata, 32'h11);
    chk("alu_d2", inst2_w2regdata, 32'h22);
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      mem_set(1, 1, 5'd6, 32'hDEAD, ops[i], 2'd2, 0, 0, 0, 0);
      settle(); clock_edge();
      mem_idle(); dmem_rdata = 32'h12F45678;
      settle();
      chk("load", inst1_w2regdata, lexp[i]);
      clock_edge();
    end
    mem_set(1, 1, 5'd5, 32'hA, 0, 0, 1, 1, 5'd5, 32'hB);
    settle(); clock_edge();
    mem_set(1, 1, 5'd0, 32'h1, 0, 0, 1, 1, 5'd0, 32'h2);
    settle();
    chk("collapse", {inst1_we, inst2_we}, 2'b01);
    chk("collapse_d", inst2_w2regdata, 32'hB);
    clock_edge();
    mem_idle();
    settle();
    chk("r0_we", {inst1_we, inst2_we}, 2'b00);
    clock_edge();
    div_valid = 1; div_wa = 5'd7; div_result = 32'h99;
    mem_set(1, 1, 5'd2, 32'h2, 0, 0, 0, 0, 0, 0);
    settle();
    chk("div_acc_ready", div_ready, 1);
    clock_edge();
    div_valid = 0; mem_idle();
    settle();
    chk("pend_p2", {inst2_we, inst2_wa}, {1'b1, 5'd7});
    chk("pend_p2_d", inst2_w2regdata, 32'h99);
    chk("pend_ready", div_ready, 0);
    chk("pend_p1", {inst1_we, inst1_wa}, {1'b1, 5'd2});
    clock_edge();
    settle();
    chk("ready_back", div_ready, 1);
    clock_edge();
    div_valid = 1; div_wa = 5'd7; div_result = 32'h77;
    mem_set(1, 1, 5'd8, 32'h80, 0, 0, 1, 1, 5'd9, 32'h90);
    settle(); clock_edge();
    div_valid = 0; n_st = 0; n_r7 = 0;
    for (int i = 0; i < 8; i++) begin
      both_busy();
      settle();
      chk("force_at", wb_stall, i == 4);
      n_st += int'(wb_stall);
      if (inst1_we && inst1_wa == 5'd7 && inst1_w2regdata == 32'h77) n_r7++;
      clock_edge();
    end
    chk("one_bubble", n_st, 1);
    chk("r7_once_p1", n_r7, 1);
    div_valid = 1; div_wa = 5'd7; div_result = 32'h55;
    mem_set(1, 1, 5'd8, 32'h80, 0, 0, 1, 1, 5'd9, 32'h90);
    settle(); clock_edge();
    div_valid = 0;
    for (int i = 0; i < 4; i++) begin
      both_busy(); settle(); clock_edge();
    end
    resetn = 0;
    settle();
    chk("rst_force", {inst1_we, inst2_we, wb_stall, div_ready}, 0);
    chk("rst_wa", {inst1_wa, inst2_wa}, 0);
    clock_edge();
    resetn = 1; mem_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("no_r7", {inst1_we, inst2_we}, 0);
      clock_edge();
    end
    for (int i = 0; i < 400; i++) begin
      if (!pstall)
        mem_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      div_valid = $urandom_range(0, 2) == 0;
      div_wa = 5'($urandom_range(0, 7));
      div_result = $urandom;
      dmem_rdata = $urandom;
      resetn = $urandom_range(0, 49) != 0;
      settle(); clock_edge();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
